// File: rtl/text_console_pkg.sv
// Shared types and constants for the text console: control characters, FSM states,
// cursor operations, holding-buffer entry and status register bit positions.
package coffee_console_pkg;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_TAB   = 8'h09;

    localparam int ST_DROP    = 31;
    localparam int ST_BUSY    = 30;
    localparam int ST_ROW_LSB = 8;
    localparam int ST_COL_LSB = 0;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        CLEAR,
        RECALC
    } con_state_e;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_ADVANCE,
        OP_NEWLINE,
        OP_CR,
        OP_BACK,
        OP_HOME,
        OP_LOAD,
        OP_TAB
    } cur_op_e;

    typedef struct packed {
        logic       vld;
        logic [7:0] data;
    } hold_t;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage

// File: rtl/text_console_if.sv
// CPU write bus plus char_ram write port and status, bundled for the text console.
interface text_console_if;
    logic [15:0] cpu_addr;
    logic [31:0] cpu_data;
    logic        cpu_wren;
    logic [11:0] char_addr;
    logic [7:0]  char_data;
    logic        char_wren;
    logic        busy;
    logic [31:0] status;

    modport master (
        output cpu_addr, cpu_data, cpu_wren,
        input  char_addr, char_data, char_wren, busy, status
    );

    modport slave (
        input  cpu_addr, cpu_data, cpu_wren,
        output char_addr, char_data, char_wren, busy, status
    );
endinterface

// File: rtl/text_console_cursor.sv
// Cursor register set (row, col, row_base = row*COLS). row_base is only ever stepped by
// +COLS or zeroed; after a load it is rebuilt one row per cycle while recalc_busy is high.
module console_cursor
    import coffee_console_pkg::*;
#(
    parameter int COLS  = 80,
    parameter int ROWS  = 30,
    parameter int TAB_W = 8
) (
    input  logic        clock,
    input  logic        nRst,
    input  cur_op_e     op,
    input  logic [7:0]  load_row,
    input  logic [7:0]  load_col,
    output logic [7:0]  row,
    output logic [7:0]  col,
    output logic [11:0] row_base,
    output logic        recalc_busy
);
    localparam logic [7:0]  LAST_COL = 8'(COLS - 1);
    localparam logic [7:0]  LAST_ROW = 8'(ROWS - 1);
    localparam logic [11:0] COLS_W   = 12'(COLS);

    logic [7:0]  calc_row;
    logic [7:0]  row_n, col_n, calc_n;
    logic [11:0] base_n;
    logic [7:0]  nl_row;
    logic [11:0] nl_base;
    logic [8:0]  tab_col;

    assign recalc_busy = (calc_row != row);

    always_comb begin
        nl_row  = (row == LAST_ROW) ? 8'd0 : row + 8'd1;
        nl_base = (row == LAST_ROW) ? 12'd0 : row_base + COLS_W;
        tab_col = 9'(col) - 9'(col % 8'(TAB_W)) + 9'(TAB_W);

        row_n  = row;
        col_n  = col;
        base_n = row_base;
        calc_n = calc_row;
        case (op)
            OP_ADVANCE: begin
                if (col == LAST_COL) begin
                    col_n  = 8'd0;
                    row_n  = nl_row;
                    base_n = nl_base;
                end else begin
                    col_n = col + 8'd1;
                end
            end
            OP_NEWLINE: begin
                col_n  = 8'd0;
                row_n  = nl_row;
                base_n = nl_base;
            end
            OP_CR:   col_n = 8'd0;
            OP_BACK: if (col != 8'd0) col_n = col - 8'd1;
            OP_HOME: begin
                row_n  = 8'd0;
                col_n  = 8'd0;
                base_n = 12'd0;
            end
            OP_LOAD: begin
                row_n  = (load_row > LAST_ROW) ? LAST_ROW : load_row;
                col_n  = (load_col > LAST_COL) ? LAST_COL : load_col;
                base_n = 12'd0;
                calc_n = 8'd0;
            end
            OP_TAB: begin
                if (tab_col > 9'(LAST_COL)) begin
                    col_n  = 8'd0;
                    row_n  = nl_row;
                    base_n = nl_base;
                end else begin
                    col_n = tab_col[7:0];
                end
            end
            default: begin
                // Idle cycles rebuild row_base after a load, one row at a time.
                if (calc_row != row) begin
                    base_n = row_base + COLS_W;
                    calc_n = calc_row + 8'd1;
                end
            end
        endcase
        if (op != OP_NONE && op != OP_LOAD) calc_n = row_n;
    end

    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            row      <= 8'd0;
            col      <= 8'd0;
            row_base <= 12'd0;
            calc_row <= 8'd0;
        end else begin
            row      <= row_n;
            col      <= col_n;
            row_base <= base_n;
            calc_row <= calc_n;
        end
    end

endmodule

// File: rtl/text_console.sv
// Byte-write CPU peripheral driving the char_ram write port: cursor, control codes,
// clear-screen sweep and a one-entry holding buffer. Build macro: CONSOLE_TAB_EN enables 0x09 tabs.
module text_console
    import coffee_console_pkg::*;
#(
    parameter int          COLS      = 80,
    parameter int          ROWS      = 30,
    parameter logic [15:0] CHAR_ADDR = 16'hFFFE,
    parameter logic [15:0] CTRL_ADDR = 16'hFFFD,
    parameter int          TAB_W     = 8
) (
    input logic           clock,
    input logic           nRst,
    text_console_if.slave bus
);
`ifdef CONSOLE_TAB_EN
    localparam bit TAB_EN = 1'b1;
`else
    localparam bit TAB_EN = 1'b0;
`endif
    localparam logic [11:0] LAST_CELL = 12'(ROWS * COLS - 1);

    con_state_e  state, state_n;
    hold_t       hold_q;
    logic        drop_q;
    logic [11:0] char_addr_q;
    logic [7:0]  char_data_q;
    logic        char_wren_q;

    logic [7:0]  row, col;
    logic [11:0] row_base;
    logic        recalc_busy;
    cur_op_e     cur_op, exec_op;

    logic        accept_char, accept_ctrl, load_req;
    logic        exec_vld, exec_wr, exec_clr, clear_last, busy;
    logic [7:0]  exec_byte, exec_data;
    logic [11:0] exec_addr;
    logic [31:0] status_w;
    logic        unused_ctrl_bits;

    assign unused_ctrl_bits = ^bus.cpu_data[29:16];

    assign accept_char = bus.cpu_wren && (bus.cpu_addr == CHAR_ADDR);
    assign accept_ctrl = bus.cpu_wren && (bus.cpu_addr == CTRL_ADDR) && (state != CLEAR);
    assign load_req    = accept_ctrl && bus.cpu_data[30];
    // A cursor load in the same cycle as a buffered byte wins; the byte runs after the reload.
    assign exec_vld    = (state == IDLE) && !load_req && (hold_q.vld || accept_char);
    assign exec_byte   = hold_q.vld ? hold_q.data : bus.cpu_data[7:0];
    assign clear_last  = (state == CLEAR) && (char_addr_q == LAST_CELL);

    always_comb begin
        exec_op   = OP_NONE;
        exec_wr   = 1'b0;
        exec_clr  = 1'b0;
        exec_data = exec_byte;
        exec_addr = row_base + 12'(col);
        if (is_printable(exec_byte)) begin
            exec_op = OP_ADVANCE;
            exec_wr = 1'b1;
        end else begin
            case (exec_byte)
                CH_LF: exec_op = OP_NEWLINE;
                CH_CR: exec_op = OP_CR;
                CH_BS: begin
                    if (col != 8'd0) begin
                        exec_op   = OP_BACK;
                        exec_wr   = 1'b1;
                        exec_data = CH_SPACE;
                        exec_addr = row_base + 12'(col) - 12'd1;
                    end
                end
                CH_FF:   exec_clr = 1'b1;
                CH_TAB:  if (TAB_EN) exec_op = OP_TAB;
                default: ;
            endcase
        end
    end

    always_comb begin
        cur_op = OP_NONE;
        if (load_req)        cur_op = OP_LOAD;
        else if (clear_last) cur_op = OP_HOME;
        else if (exec_vld)   cur_op = exec_op;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (load_req)      state_n = RECALC;
                else if (exec_vld) state_n = exec_clr ? CLEAR : EXEC;
            end
            EXEC:    state_n = load_req ? RECALC : IDLE;
            CLEAR:   if (clear_last) state_n = IDLE;
            RECALC:  if (!load_req && !recalc_busy) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            hold_q <= '0;
            drop_q <= 1'b0;
        end else begin
            if (accept_ctrl && bus.cpu_data[31]) drop_q <= 1'b0;
            if (exec_vld && hold_q.vld) begin
                hold_q <= accept_char ? '{vld: 1'b1, data: bus.cpu_data[7:0]} : '0;
            end else if (accept_char && !exec_vld) begin
                if (!hold_q.vld) hold_q <= '{vld: 1'b1, data: bus.cpu_data[7:0]};
                else             drop_q <= 1'b1;
            end
        end
    end

    // The clear sweep uses char_addr itself as its address counter.
    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            char_addr_q <= 12'd0;
            char_data_q <= 8'd0;
            char_wren_q <= 1'b0;
        end else if (state == CLEAR) begin
            if (clear_last) char_wren_q <= 1'b0;
            else            char_addr_q <= char_addr_q + 12'd1;
        end else begin
            char_wren_q <= 1'b0;
            if (exec_vld && exec_clr) begin
                char_wren_q <= 1'b1;
                char_addr_q <= 12'd0;
                char_data_q <= CH_SPACE;
            end else if (exec_vld && exec_wr) begin
                char_wren_q <= 1'b1;
                char_addr_q <= exec_addr;
                char_data_q <= exec_data;
            end
        end
    end

    console_cursor #(
        .COLS  (COLS),
        .ROWS  (ROWS),
        .TAB_W (TAB_W)
    ) u_cursor (
        .clock       (clock),
        .nRst        (nRst),
        .op          (cur_op),
        .load_row    (bus.cpu_data[15:8]),
        .load_col    (bus.cpu_data[7:0]),
        .row         (row),
        .col         (col),
        .row_base    (row_base),
        .recalc_busy (recalc_busy)
    );

    assign busy = (state == CLEAR) || (state == RECALC) || hold_q.vld;

    always_comb begin
        status_w                    = '0;
        status_w[ST_DROP]           = drop_q;
        status_w[ST_BUSY]           = busy;
        status_w[ST_ROW_LSB +: 8]   = row;
        status_w[ST_COL_LSB +: 8]   = col;
    end

    assign bus.char_addr = char_addr_q;
    assign bus.char_data = char_data_q;
    assign bus.char_wren = char_wren_q;
    assign bus.busy      = busy;
    assign bus.status    = status_w;

endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console: putchar path, wraps, clear sweep, buffer/drop, control codes, reset.
module tb_text_console;
    logic clock = 1'b0;
    logic nRst  = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    text_console_if bus();

    text_console dut (
        .clock (clock),
        .nRst  (nRst),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, required to finish");
        $fatal(1);
    end

    task automatic cpu_write(input logic [15:0] a, input logic [31:0] d);
        @(negedge clock);
        bus.cpu_addr = a;
        bus.cpu_data = d;
        bus.cpu_wren = 1'b1;
        @(negedge clock);
        bus.cpu_wren = 1'b0;
    endtask

    task automatic wait_not_busy(input int max_cyc, input string name);
        int c = 0;
        while (bus.busy === 1'b1 && c < max_cyc) begin
            @(negedge clock);
            c++;
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: busy=%b after %0d cycles, required 0", name, bus.busy, c);
        end
    endtask

    task automatic test_reset();
        bus.cpu_addr = 16'h0;
        bus.cpu_data = 32'h0;
        bus.cpu_wren = 1'b0;
        nRst = 1'b0;
        repeat (3) @(negedge clock);
        nRst = 1'b1;
        @(negedge clock);
        n_checks++; if (bus.char_wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren: got %b, required 0", bus.char_wren); end
        n_checks++; if (bus.char_addr !== 12'd0) begin n_fail++; $display("FAIL reset_addr: got %0d, required 0", bus.char_addr); end
        n_checks++; if (bus.char_data !== 8'd0) begin n_fail++; $display("FAIL reset_data: got %h, required 00", bus.char_data); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
        n_checks++; if (bus.status !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h, required 00000000", bus.status); end
    endtask

    task automatic test_single_char();
        cpu_write(16'hFFFE, 32'h41);
        n_checks++; if ({bus.char_wren, bus.char_addr, bus.char_data} !== {1'b1, 12'd0, 8'h41}) begin
            n_fail++; $display("FAIL single_write: got wren=%b addr=%0d data=%h, required 1/0/41", bus.char_wren, bus.char_addr, bus.char_data); end
        n_checks++; if (bus.status !== 32'h0000_0001) begin n_fail++; $display("FAIL single_status: got %h, required 00000001", bus.status); end
        @(negedge clock);
        n_checks++; if (bus.char_wren !== 1'b0) begin n_fail++; $display("FAIL single_pulse: wren got %b, required 0", bus.char_wren); end
    endtask

    task automatic test_line_wrap();
        logic [7:0] ch;
        cpu_write(16'hFFFD, 32'h4000_0000);
        wait_not_busy(10, "home_recalc");
        for (int i = 0; i < 80; i++) begin
            ch = 8'h41 + 8'(i % 26);
            cpu_write(16'hFFFE, {24'h0, ch});
            n_checks++; if ({bus.char_wren, bus.char_addr, bus.char_data} !== {1'b1, 12'(i), ch}) begin
                n_fail++; $display("FAIL line_write_%0d: got wren=%b addr=%0d data=%h, required 1/%0d/%h", i, bus.char_wren, bus.char_addr, bus.char_data, i, ch); end
        end
        n_checks++; if (bus.status !== 32'h0000_0100) begin n_fail++; $display("FAIL line_wrap_status: got %h, required 00000100", bus.status); end
        cpu_write(16'hFFFE, 32'h42);
        n_checks++; if ({bus.char_wren, bus.char_addr, bus.char_data} !== {1'b1, 12'd80, 8'h42}) begin
            n_fail++; $display("FAIL row1_write: got wren=%b addr=%0d data=%h, required 1/80/42", bus.char_wren, bus.char_addr, bus.char_data); end
    endtask

    task automatic test_screen_wrap();
        cpu_write(16'hFFFD, 32'h4000_FFFF);
        wait_not_busy(40, "clamp_recalc");
        n_checks++; if (bus.status !== 32'h0000_1D4F) begin n_fail++; $display("FAIL clamp_status: got %h, required 00001D4F", bus.status); end
        cpu_write(16'hFFFD, 32'h4000_1D4F);
        wait_not_busy(40, "load_recalc");
        n_checks++; if (bus.status !== 32'h0000_1D4F) begin n_fail++; $display("FAIL load_status: got %h, required 00001D4F", bus.status); end
        cpu_write(16'hFFFE, 32'h5A);
        n_checks++; if ({bus.char_wren, bus.char_addr, bus.char_data} !== {1'b1, 12'd2399, 8'h5A}) begin
            n_fail++; $display("FAIL last_cell: got wren=%b addr=%0d data=%h, required 1/2399/5A", bus.char_wren, bus.char_addr, bus.char_data); end
        n_checks++; if (bus.status !== 32'h0) begin n_fail++; $display("FAIL screen_wrap_status: got %h, required 00000000", bus.status); end
    endtask

    task automatic test_clear();
        int pulses = 0;
        int bad = 0;
        int cyc = 0;
        cpu_write(16'hFFFE, 32'h0C);
        while (cyc < 3000) begin
            if (bus.char_wren !== 1'b1) break;
            if (bus.char_addr !== 12'(pulses) || bus.char_data !== 8'h20 || bus.busy !== 1'b1) bad++;
            pulses++;
            if (pulses == 100) begin
                bus.cpu_addr = 16'hFFFE; bus.cpu_data = 32'h58; bus.cpu_wren = 1'b1;
            end else if (pulses == 200) begin
                bus.cpu_addr = 16'hFFFE; bus.cpu_data = 32'h59; bus.cpu_wren = 1'b1;
            end else begin
                bus.cpu_wren = 1'b0;
            end
            @(negedge clock);
            cyc++;
        end
        bus.cpu_wren = 1'b0;
        n_checks++; if (pulses != 2400) begin n_fail++; $display("FAIL clear_pulses: got %0d, required 2400", pulses); end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL clear_sweep: %0d bad cycles, required 0", bad); end
        n_checks++; if (bus.status !== 32'hC000_0000) begin n_fail++; $display("FAIL clear_end_status: got %h, required C0000000", bus.status); end
        @(negedge clock);
        n_checks++; if ({bus.char_wren, bus.char_addr, bus.char_data} !== {1'b1, 12'd0, 8'h58}) begin
            n_fail++; $display("FAIL buffered_exec: got wren=%b addr=%0d data=%h, required 1/0/58", bus.char_wren, bus.char_addr, bus.char_data); end
        n_checks++; if (bus.status !== 32'h8000_0001) begin n_fail++; $display("FAIL drop_status: got %h, required 80000001", bus.status); end
        cpu_write(16'hFFFD, 32'h8000_0000);
        n_checks++; if (bus.status !== 32'h0000_0001) begin n_fail++; $display("FAIL drop_clear: got %h, required 00000001", bus.status); end
    endtask

    task automatic test_codes();
        cpu_write(16'hFFFE, 32'h0D);
        n_checks++; if ({bus.char_wren, bus.status} !== {1'b0, 32'h0}) begin n_fail++; $display("FAIL cr: got wren=%b status=%h, required 0/00000000", bus.char_wren, bus.status); end
        cpu_write(16'hFFFE, 32'h08);
        n_checks++; if ({bus.char_wren, bus.status} !== {1'b0, 32'h0}) begin n_fail++; $display("FAIL bs_col0: got wren=%b status=%h, required 0/00000000", bus.char_wren, bus.status); end
        cpu_write(16'hFFFD, 32'h4000_0005);
        wait_not_busy(10, "col5_recalc");
        cpu_write(16'hFFFE, 32'h08);
        n_checks++; if ({bus.char_wren, bus.char_addr, bus.char_data} !== {1'b1, 12'd4, 8'h20}) begin
            n_fail++; $display("FAIL bs_write: got wren=%b addr=%0d data=%h, required 1/4/20", bus.char_wren, bus.char_addr, bus.char_data); end
        n_checks++; if (bus.status !== 32'h0000_0004) begin n_fail++; $display("FAIL bs_status: got %h, required 00000004", bus.status); end
        cpu_write(16'hFFFE, 32'h0A);
        n_checks++; if ({bus.char_wren, bus.status} !== {1'b0, 32'h0000_0100}) begin n_fail++; $display("FAIL lf: got wren=%b status=%h, required 0/00000100", bus.char_wren, bus.status); end
        cpu_write(16'hFFFE, 32'h01);
        n_checks++; if ({bus.char_wren, bus.status} !== {1'b0, 32'h0000_0100}) begin n_fail++; $display("FAIL ignored: got wren=%b status=%h, required 0/00000100", bus.char_wren, bus.status); end
        cpu_write(16'hFFFD, 32'h4000_0003);
        wait_not_busy(10, "col3_recalc");
        cpu_write(16'hFFFE, 32'h09);
`ifdef CONSOLE_TAB_EN
        n_checks++; if ({bus.char_wren, bus.status} !== {1'b0, 32'h0000_0008}) begin n_fail++; $display("FAIL tab: got wren=%b status=%h, required 0/00000008", bus.char_wren, bus.status); end
`else
        n_checks++; if ({bus.char_wren, bus.status} !== {1'b0, 32'h0000_0003}) begin n_fail++; $display("FAIL tab_ignored: got wren=%b status=%h, required 0/00000003", bus.char_wren, bus.status); end
`endif
    endtask

    task automatic test_back_to_back();
        cpu_write(16'hFFFD, 32'h4000_0000);
        wait_not_busy(10, "b2b_home");
        @(negedge clock);
        bus.cpu_addr = 16'hFFFE; bus.cpu_data = 32'h61; bus.cpu_wren = 1'b1;
        @(negedge clock);
        n_checks++; if ({bus.char_wren, bus.char_addr, bus.char_data} !== {1'b1, 12'd0, 8'h61}) begin
            n_fail++; $display("FAIL b2b_first: got wren=%b addr=%0d data=%h, required 1/0/61", bus.char_wren, bus.char_addr, bus.char_data); end
        bus.cpu_data = 32'h62;
        @(negedge clock);
        bus.cpu_wren = 1'b0;
        n_checks++; if ({bus.char_wren, bus.busy} !== 2'b01) begin n_fail++; $display("FAIL b2b_buffered: got wren=%b busy=%b, required 0/1", bus.char_wren, bus.busy); end
        @(negedge clock);
        n_checks++; if ({bus.char_wren, bus.char_addr, bus.char_data} !== {1'b1, 12'd1, 8'h62}) begin
            n_fail++; $display("FAIL b2b_second: got wren=%b addr=%0d data=%h, required 1/1/62", bus.char_wren, bus.char_addr, bus.char_data); end
        n_checks++; if (bus.status !== 32'h0000_0002) begin n_fail++; $display("FAIL b2b_status: got %h, required 00000002", bus.status); end
    endtask

    task automatic test_reset_mid_clear();
        cpu_write(16'hFFFE, 32'h0C);
        repeat (50) @(negedge clock);
        n_checks++; if ({bus.char_wren, bus.busy} !== 2'b11) begin n_fail++; $display("FAIL mid_clear: got wren=%b busy=%b, required 1/1", bus.char_wren, bus.busy); end
        nRst = 1'b0;
        #1;
        n_checks++; if ({bus.busy, bus.char_wren, bus.status} !== {1'b0, 1'b0, 32'h0}) begin
            n_fail++; $display("FAIL abort_clear: got busy=%b wren=%b status=%h, required 0/0/00000000", bus.busy, bus.char_wren, bus.status); end
        @(negedge clock);
        nRst = 1'b1;
        cpu_write(16'hFFFE, 32'h51);
        n_checks++; if ({bus.char_wren, bus.char_addr, bus.char_data} !== {1'b1, 12'd0, 8'h51}) begin
            n_fail++; $display("FAIL after_abort: got wren=%b addr=%0d data=%h, required 1/0/51", bus.char_wren, bus.char_addr, bus.char_data); end
    endtask

    initial begin
        test_reset();
        test_single_char();
        test_line_wrap();
        test_screen_wrap();
        test_clear();
        test_codes();
        test_back_to_back();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
